// File: rtl/passcode_decrypt_checker.sv
// Serial passcode checker: decrypts keypad digits, compares the code, locks out after repeated failures.
// Latency 1 cycle for dec_digit and 2 for match/mismatch; backpressure via digit_ready, low in CHECK and LOCKED.
module passcode_decrypt_checker #(
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    localparam int AW = $clog2(MAX_ATTEMPTS + 1),
    localparam int IW = $clog2(NUM_DIGITS + 1),
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [3:0]              digit_in,
    input  logic                    digit_valid,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] ref_code,
    output logic                    digit_ready,
    output logic [3:0]              dec_digit,
    output logic                    dec_valid,
    output logic                    match,
    output logic                    mismatch,
    output logic                    locked,
    output logic [AW-1:0]           attempts_left
);

    typedef enum logic [1:0] {S_COLLECT, S_CHECK, S_LOCKED} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic              r_bad;
    logic [3:0]        r_slot [NUM_DIGITS];
    logic [LW-1:0]     r_lock_cnt;
    logic [3:0]        r_dec_digit;
    logic              r_dec_valid;
    logic              r_match;
    logic              r_mismatch;
    logic              r_locked;
    logic [AW-1:0]     r_att;

    logic [3:0]              w_dec;
    logic [4*NUM_DIGITS-1:0] w_code;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_equal;

    function automatic logic [3:0] decrypt(input logic [3:0] d);
        case (d)
            4'd0:    decrypt = 4'd5;
            4'd1:    decrypt = 4'd3;
            4'd2:    decrypt = 4'd6;
            4'd3:    decrypt = 4'd1;
            4'd4:    decrypt = 4'd9;
            4'd5:    decrypt = 4'd2;
            4'd6:    decrypt = 4'd8;
            4'd7:    decrypt = 4'd0;
            4'd8:    decrypt = 4'd7;
            4'd9:    decrypt = 4'd4;
            default: decrypt = 4'hF;
        endcase
    endfunction

    assign w_dec    = decrypt(digit_in);
    assign w_accept = digit_valid && (r_state == S_COLLECT) && !clear;
    assign w_last   = (r_idx == IW'(NUM_DIGITS - 1));
    // An out-of-range digit poisons the attempt even if ref_code holds F in that slot.
    assign w_equal  = (w_code == ref_code) && !r_bad;

    always_comb begin
        w_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_code[4*i +: 4] = r_slot[i];
        end
    end

    // Slot contents need no reset: idx restarts at 0 so stale slots are always overwritten.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_accept && (r_idx == IW'(i))) begin
                r_slot[i] <= w_dec;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_COLLECT;
            r_idx       <= '0;
            r_bad       <= 1'b0;
            r_lock_cnt  <= '0;
            r_dec_digit <= 4'd0;
            r_dec_valid <= 1'b0;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_locked    <= 1'b0;
            r_att       <= AW'(MAX_ATTEMPTS);
        end else begin
            r_dec_valid <= 1'b0;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (clear) begin
                        r_idx <= '0;
                        r_bad <= 1'b0;
                    end else if (w_accept) begin
                        r_dec_digit <= w_dec;
                        r_dec_valid <= 1'b1;
                        if (w_dec == 4'hF) begin
                            r_bad <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    r_idx <= '0;
                    r_bad <= 1'b0;
                    if (w_equal) begin
                        r_match <= 1'b1;
                        r_att   <= AW'(MAX_ATTEMPTS);
                        r_state <= S_COLLECT;
                    end else begin
                        r_mismatch <= 1'b1;
                        r_att      <= r_att - AW'(1);
                        if (r_att == AW'(1)) begin
                            r_state    <= S_LOCKED;
                            r_locked   <= 1'b1;
                            r_lock_cnt <= LW'(LOCKOUT_CYCLES);
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_LOCKED: begin
                    if (r_lock_cnt == LW'(1)) begin
                        r_state  <= S_COLLECT;
                        r_locked <= 1'b0;
                        r_att    <= AW'(MAX_ATTEMPTS);
                    end else begin
                        r_lock_cnt <= r_lock_cnt - LW'(1);
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign digit_ready   = (r_state == S_COLLECT);
    assign dec_digit     = r_dec_digit;
    assign dec_valid     = r_dec_valid;
    assign match         = r_match;
    assign mismatch      = r_mismatch;
    assign locked        = r_locked;
    assign attempts_left = r_att;

endmodule

// File: tb/tb_passcode_decrypt_checker.sv
// Bench for passcode_decrypt_checker: queue-based reference model checked every cycle plus directed literals.
module tb_passcode_decrypt_checker;

    localparam int N  = 4;
    localparam int MA = 3;
    localparam int LC = 1000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] ref_code = 16'h4321;
    logic        digit_ready;
    logic [3:0]  dec_digit;
    logic        dec_valid;
    logic        match;
    logic        mismatch;
    logic        locked;
    logic [1:0]  attempts_left;

    passcode_decrypt_checker #(
        .NUM_DIGITS(N), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
    ) dut (
        .Clk(Clk), .Rst(Rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .clear(clear), .ref_code(ref_code), .digit_ready(digit_ready),
        .dec_digit(dec_digit), .dec_valid(dec_valid), .match(match),
        .mismatch(mismatch), .locked(locked), .attempts_left(attempts_left)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of plaintext digits, a pending-verdict flag and a lockout countdown.
    int tbl [16] = '{5, 3, 6, 1, 9, 2, 8, 0, 7, 4, 15, 15, 15, 15, 15, 15};
    int q [$];
    bit m_init = 0;
    bit m_check = 0;
    int m_lock = 0;
    int m_att = MA;
    int e_dec = 0;
    bit e_dv = 0;
    bit e_m = 0;
    bit e_mm = 0;

    always @(posedge Clk) begin
        bit ok;
        e_dv = 0;
        e_m  = 0;
        e_mm = 0;
        if (Rst) begin
            q.delete();
            m_check = 0;
            m_lock  = 0;
            m_att   = MA;
            e_dec   = 0;
            m_init  = 1;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_att = MA;
        end else if (m_check) begin
            ok = 1;
            foreach (q[i]) begin
                if (q[i] == 15 || q[i] != int'((ref_code >> (4 * i)) & 16'hF)) ok = 0;
            end
            if (ok) begin
                e_m   = 1;
                m_att = MA;
            end else begin
                e_mm = 1;
                m_att--;
                if (m_att == 0) m_lock = LC;
            end
            q.delete();
            m_check = 0;
        end else if (clear) begin
            q.delete();
        end else if (digit_valid) begin
            e_dec = tbl[digit_in];
            e_dv  = 1;
            q.push_back(e_dec);
            if (q.size() == N) m_check = 1;
        end
    end

    always @(negedge Clk) begin
        if (m_init) begin
            chk("digit_ready", 32'(digit_ready), 32'(!m_check && m_lock == 0));
            chk("dec_digit", 32'(dec_digit), 32'(e_dec));
            chk("dec_valid", 32'(dec_valid), 32'(e_dv));
            chk("match", 32'(match), 32'(e_m));
            chk("mismatch", 32'(mismatch), 32'(e_mm));
            chk("locked", 32'(locked), 32'(m_lock > 0));
            chk("attempts_left", 32'(attempts_left), 32'(m_att));
        end
    end

    task automatic send(input logic [3:0] d, output logic [3:0] dv);
        int n;
        n = 0;
        while (!digit_ready && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (!digit_ready) chk("send_timeout", 32'(0), 32'(1));
        digit_valid = 1'b1;
        digit_in    = d;
        @(negedge Clk);
        digit_valid = 1'b0;
        dv          = dec_digit;
    endtask

    // digs nibble i is the i-th digit entered
    task automatic enter(input logic [15:0] digs, output logic [15:0] decs);
        logic [3:0] d;
        for (int i = 0; i < N; i++) begin
            send(digs[4*i +: 4], d);
            decs[4*i +: 4] = d;
        end
    endtask

    task automatic verdict(input string name, input logic exp_match, input logic [1:0] exp_att);
        @(negedge Clk);
        chk({name, "_match"}, 32'(match), 32'(exp_match));
        chk({name, "_mismatch"}, 32'(mismatch), 32'(!exp_match));
        chk({name, "_attempts"}, 32'(attempts_left), 32'(exp_att));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [15:0] decs;
        logic [3:0]  d;
        int          n;

        // T1 reset
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_ready", 32'(digit_ready), 32'(1));
        chk("rst_attempts", 32'(attempts_left), 32'(3));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_pulses", 32'({dec_valid, match, mismatch}), 32'(0));
        chk("rst_dec", 32'(dec_digit), 32'(0));
        Rst = 1'b0;
        @(negedge Clk);

        // T2 match: 3,5,1,9 -> 1,2,3,4
        enter(16'h9153, decs);
        chk("t2_decs", 32'(decs), 32'h4321);
        verdict("t2", 1'b1, 2'd3);

        // T3 lockout
        enter(16'h0000, decs);
        chk("t3_decs", 32'(decs), 32'h5555);
        verdict("t3a", 1'b0, 2'd2);
        enter(16'h0000, decs);
        verdict("t3b", 1'b0, 2'd1);
        enter(16'h0000, decs);
        verdict("t3c", 1'b0, 2'd0);
        chk("t3_locked", 32'(locked), 32'(1));
        chk("t3_ready_locked", 32'(digit_ready), 32'(0));
        n = 1;
        digit_valid = 1'b1;
        digit_in    = 4'd3;
        clear       = 1'b1;
        while (n < 3000) begin
            @(negedge Clk);
            if (!locked) break;
            n++;
        end
        digit_valid = 1'b0;
        clear       = 1'b0;
        chk("t3_lock_cycles", 32'(n), 32'(1000));
        chk("t3_after_attempts", 32'(attempts_left), 32'(3));
        chk("t3_after_ready", 32'(digit_ready), 32'(1));

        // T4 invalid digit: 3,A,1,9 -> 1,F,3,4
        enter(16'h91A3, decs);
        chk("t4_decs", 32'(decs), 32'h43F1);
        verdict("t4", 1'b0, 2'd2);
        // F in the reference must not rescue an invalid digit
        ref_code = 16'h43F1;
        enter(16'h91A3, decs);
        verdict("t4b", 1'b0, 2'd1);
        ref_code = 16'h4321;

        // T5 clear beats a simultaneous digit
        send(4'd3, d);
        send(4'd5, d);
        ref_code    = 16'hFFFF;
        clear       = 1'b1;
        digit_valid = 1'b1;
        digit_in    = 4'd1;
        @(negedge Clk);
        clear       = 1'b0;
        digit_valid = 1'b0;
        chk("t5_dropped", 32'(dec_valid), 32'(0));
        ref_code = 16'h4321;
        enter(16'h9153, decs);
        verdict("t5", 1'b1, 2'd3);

        // T6 recovery after two mismatches, then reset mid-lockout
        enter(16'h0000, decs);
        verdict("t6a", 1'b0, 2'd2);
        enter(16'h0000, decs);
        verdict("t6b", 1'b0, 2'd1);
        enter(16'h9153, decs);
        verdict("t6c", 1'b1, 2'd3);
        for (int k = 0; k < 3; k++) begin
            enter(16'h0000, decs);
            @(negedge Clk);
        end
        chk("t6_locked", 32'(locked), 32'(1));
        repeat (10) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("t6_rst_locked", 32'(locked), 32'(0));
        chk("t6_rst_ready", 32'(digit_ready), 32'(1));
        chk("t6_rst_attempts", 32'(attempts_left), 32'(3));
        @(negedge Clk);
        enter(16'h9153, decs);
        verdict("t6d", 1'b1, 2'd3);

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
